// File: rtl/can_pkg.sv
// Shared CAN bit-timing constants and TX state encoding, imported by both the TX bit engine
// and the RX sampler so the two paths always agree on bit length and sample point.
package can_pkg;

  function automatic int clks_per_bit(input int clk_mhz, input int bit_rate_kbits);
    return clk_mhz * 1000 / bit_rate_kbits;
  endfunction

  localparam int CLK_SPEED_MHZ      = 100;
  localparam int CAN_BIT_RATE_KBITS = 1000;
  localparam int CLKS_PER_BIT       = clks_per_bit(CLK_SPEED_MHZ, CAN_BIT_RATE_KBITS);
  localparam int SAMPLE_PT          = CLKS_PER_BIT / 2 - 1;

  // Same-polarity run length that forces a complementary stuff bit.
  localparam logic [2:0] STUFF_LIMIT = 3'd5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SOF   = 2'd1,
    TX_DATA  = 2'd2,
    TX_STUFF = 2'd3
  } tx_state_t;

endpackage

// File: rtl/can_tx_bitgen_if.sv
// Frame-builder <-> TX bit engine handshake: bit stream with valid/ready plus frame status.
interface can_tx_bitgen_if;
  logic start;
  logic din;
  logic din_valid;
  logic din_last;
  logic din_ready;
  logic stuff_en;
  logic arb_en;
  logic busy;
  logic done;
  logic underrun;
  logic arb_lost;

  modport master (
    output start, din, din_valid, din_last, stuff_en, arb_en,
    input  din_ready, busy, done, underrun, arb_lost
  );

  modport slave (
    input  start, din, din_valid, din_last, stuff_en, arb_en,
    output din_ready, busy, done, underrun, arb_lost
  );
endinterface

// File: rtl/can_bit_timer.sv
// Free-running CAN bit-period counter with bit_end and sample_pt strobes; shared with the RX sampler.
module can_bit_timer #(
  parameter int CLKS_PER_BIT = can_pkg::CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic bit_end,
  output logic sample_pt
);
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SAMPLE = CLKS_PER_BIT / 2 - 1;

  logic [CNT_W-1:0] cnt;

  assign bit_end   = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign sample_pt = en && (cnt == CNT_W'(SAMPLE));

  always_ff @(posedge clk) begin
    if (!rst_n)       cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (bit_end) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/can_tx_bitgen.sv
// CAN TX bit engine: SOF, serialisation at the bit rate and stuff-bit insertion onto TXD.
// Define CAN_TX_ARB_MON_EN to enable arbitration-loss monitoring of RXD during the ID/RTR field.
module can_tx_bitgen
  import can_pkg::*;
#(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  can_tx_bitgen_if.slave   bus,
  input  logic             can_rx,
  output logic             can_tx
);
  localparam int BIT_CLKS = clks_per_bit(clk_speed_MHz, can_bit_rate_Kbits);

  tx_state_t  state_q, state_n;
  logic       tx_n;
  logic       run_last_q, run_last_n;
  logic [2:0] run_cnt_q, run_cnt_n;
  logic       fin_q, fin_n;
  logic       done_q, done_n, underrun_q, underrun_n, arb_lost_q, arb_lost_n;
  logic       bit_end, sample_pt, active, stuff_now, arb_hit;

  assign active       = (state_q != TX_IDLE);
  assign bus.busy     = active;
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;
  assign bus.arb_lost = arb_lost_q;

  can_bit_timer #(.CLKS_PER_BIT(BIT_CLKS)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (active),
    .clear     (!active && bus.start),
    .bit_end   (bit_end),
    .sample_pt (sample_pt)
  );

`ifdef CAN_TX_ARB_MON_EN
  // Only a recessive data bit read back as dominant means another node won the bus.
  assign arb_hit = sample_pt && bus.arb_en && (state_q == TX_DATA) && can_tx && !can_rx;
`else
  logic unused_arb;
  assign unused_arb = &{1'b0, sample_pt, bus.arb_en, can_rx};
  assign arb_hit    = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_n;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    stuff_now     = 1'b0;
    bus.din_ready = 1'b0;
    if (active && bit_end && !fin_q) begin
      if (bus.stuff_en && (run_cnt_q == STUFF_LIMIT)) stuff_now     = 1'b1;
      else                                             bus.din_ready = 1'b1;
    end
  end

  always_comb begin
    state_n    = state_q;
    tx_n       = can_tx;
    run_last_n = run_last_q;
    run_cnt_n  = run_cnt_q;
    fin_n      = fin_q;
    done_n     = 1'b0;
    underrun_n = 1'b0;
    arb_lost_n = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (bus.start) begin
          state_n    = TX_SOF;
          tx_n       = 1'b0;
          run_last_n = 1'b0;
          run_cnt_n  = 3'd1;
          fin_n      = 1'b0;
        end
      end
      default: begin
        if (bit_end) begin
          if (fin_q) begin
            state_n = TX_IDLE;
            tx_n    = 1'b1;
            done_n  = 1'b1;
          end else if (stuff_now) begin
            state_n    = TX_STUFF;
            tx_n       = ~run_last_q;
            run_last_n = ~run_last_q;
            run_cnt_n  = 3'd1;
          end else if (bus.din_valid) begin
            state_n    = TX_DATA;
            tx_n       = bus.din;
            run_last_n = bus.din;
            fin_n      = bus.din_last;
            if (bus.din != run_last_q)         run_cnt_n = 3'd1;
            else if (run_cnt_q != STUFF_LIMIT) run_cnt_n = run_cnt_q + 3'd1;
          end else begin
            state_n    = TX_IDLE;
            tx_n       = 1'b1;
            underrun_n = 1'b1;
          end
        end else if (arb_hit) begin
          state_n    = TX_IDLE;
          tx_n       = 1'b1;
          arb_lost_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      can_tx     <= 1'b1;
      run_last_q <= 1'b0;
      run_cnt_q  <= 3'd0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      arb_lost_q <= 1'b0;
    end else begin
      can_tx     <= tx_n;
      run_last_q <= run_last_n;
      run_cnt_q  <= run_cnt_n;
      fin_q      <= fin_n;
      done_q     <= done_n;
      underrun_q <= underrun_n;
      arb_lost_q <= arb_lost_n;
    end
  end
endmodule

// File: tb/tb_can_tx_bitgen.sv
// Directed bench for can_tx_bitgen: frame waveforms, stuffing, underrun, reset and (optionally) arbitration loss.
module tb_can_tx_bitgen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic can_tx, can_rx;
  logic force_dom = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  can_tx_bitgen_if bus ();

  // Bus loopback; the bench can pull RXD dominant to emulate another node.
  assign can_rx = force_dom ? 1'b0 : can_tx;

  can_tx_bitgen dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .can_rx (can_rx),
    .can_tx (can_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; cycle c=1 is the first cycle after the start edge.
  // exp_kind: 0 done, 1 underrun, 2 arb_lost. force_at: cycle with RXD pulled dominant (0 = never).
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits,
                           input logic se, input logic ae, input logic [15:0] exp_lvl,
                           input int exp_end, input int exp_kind, input int exp_rdy,
                           input int force_at);
    int   idx = 0, c = 1, p, glitch = 0, rdy = 0, kind = -1, end_c = 0;
    logic acc;
    bus.stuff_en  = se;
    bus.arb_en    = ae;
    bus.din_valid = (nbits > 0);
    bus.din       = (nbits > 0) ? bits[0] : 1'b1;
    bus.din_last  = (nbits == 1);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " busy_after_start"}, bus.busy, 1);
    check({tag, " sof_level"}, can_tx, 0);
    while (c <= 2000) begin
      if (bus.done || bus.underrun || bus.arb_lost) begin
        end_c = c;
        kind  = bus.done ? 0 : (bus.underrun ? 1 : 2);
        break;
      end
      force_dom = (c == force_at);
      p = (c - 1) / 100;
      if (p > 15 || can_tx !== exp_lvl[p]) glitch++;
      if ((c - 1) % 100 == 50 && p <= 15)
        check($sformatf("%s bit%0d", tag, p), can_tx, exp_lvl[p]);
      acc = bus.din_ready && bus.din_valid;
      if (bus.din_ready) rdy++;
      tick();
      c++;
      if (acc) idx++;
      bus.din_valid = (idx < nbits);
      bus.din       = (idx < nbits) ? bits[idx] : 1'b1;
      bus.din_last  = (idx == nbits - 1);
    end
    force_dom = 1'b0;
    check({tag, " end_cycle"}, end_c, exp_end);
    check({tag, " end_kind"}, kind, exp_kind);
    check({tag, " waveform_glitches"}, glitch, 0);
    check({tag, " din_ready_pulses"}, rdy, exp_rdy);
    check({tag, " txd_idle"}, can_tx, 1);
    check({tag, " busy_low"}, bus.busy, 0);
    tick();
    check({tag, " pulses_cleared"}, {bus.done, bus.underrun, bus.arb_lost}, 0);
    bus.din_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int pulses;
    bus.start = 1'b0; bus.din = 1'b1; bus.din_valid = 1'b0; bus.din_last = 1'b0;
    bus.stuff_en = 1'b0; bus.arb_en = 1'b0;
    repeat (3) tick();
    check("reset can_tx", can_tx, 1);
    check("reset status", {bus.busy, bus.done, bus.underrun, bus.arb_lost, bus.din_ready}, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle can_tx", can_tx, 1);
    check("idle din_ready", bus.din_ready, 0);

    // 1,0,1 last: SOF 0, then 1,0,1; done 400 clk after the start edge.
    run_frame("f101", 16'b101, 3, 1'b1, 1'b0, 16'b1010, 401, 0, 3, 0);
    // SOF + four 0s = five dominant -> stuff 1, then data 1.
    run_frame("stuff1", 16'b10000, 5, 1'b1, 1'b0, 16'b1100000, 701, 0, 5, 0);
    // Six 1s then 0 with stuffing off: no insertion.
    run_frame("nostuff", 16'b0111111, 7, 1'b0, 1'b0, 16'b01111110, 801, 0, 7, 0);
    // Same bits with stuffing on: stuff 0 after the 5th 1.
    run_frame("stuff0", 16'b0111111, 7, 1'b1, 1'b0, 16'b010111110, 901, 0, 7, 0);
    // No data at the first boundary.
    run_frame("underrun", 16'b0, 0, 1'b1, 1'b0, 16'b0, 101, 1, 1, 0);

`ifdef CAN_TX_ARB_MON_EN
    run_frame("arb_lost", 16'b011, 3, 1'b0, 1'b1, 16'b10, 151, 2, 1, 150);
    run_frame("arb_off", 16'b011, 3, 1'b0, 1'b0, 16'b0110, 401, 0, 3, 150);
`endif

    // Reset mid DATA bit; a start while busy must be ignored.
    bus.stuff_en = 1'b0; bus.din = 1'b1; bus.din_valid = 1'b1; bus.din_last = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (119) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (130) tick();
    check("busy_start_ignored can_tx", can_tx, 1);
    check("busy_start_ignored busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset can_tx", can_tx, 1);
    check("midreset busy", bus.busy, 0);
    check("midreset pulses", {bus.done, bus.underrun}, 0);
    bus.din_valid = 1'b0;
    pulses = 0;
    repeat (300) begin
      tick();
      if (bus.done || bus.underrun || bus.busy) pulses++;
    end
    check("midreset quiet", pulses, 0);
    run_frame("after_reset", 16'b101, 3, 1'b1, 1'b0, 16'b1010, 401, 0, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end
endmodule
